credit_tx: RTL and testbench
============================

# credit_tx

Credit-based link transmitter that sits directly upstream of the team's credit-based receive FIFO. Accepts words from a ready/valid source and forwards them over a link that has no ready signal. Sends a word only while it holds a credit, and reclaims credits returned by the receiving FIFO as it drains. Includes an enable/drain state machine so the link can be quiesced cleanly, with all credits home, before reconfiguration.

## Interface
- Data_W, 32, payload width in bits
- CREDITS, 8, initial credit count; equals the receiving FIFO's DEPTH; must be ≥ 1
- CNT_W, $clog2(CREDITS+1), derived localparam; width of every credit count

- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- link_en  input  1  level; 1 = run the link, 0 = request drain
- s_valid  input  1  source has a word
- s_ready  output  1  transmitter accepts the word this cycle
- s_data  input  Data_W  source word
- tx_valid  output  1  link word valid; the receiver must accept it
- tx_data  output  Data_W  link word
- cr_ret_valid  input  1  credit-return strobe from the receiver
- cr_ret_cnt  input  CNT_W  number of credits returned when strobed (0..CREDITS)
- credits  output  CNT_W  credits currently held
- inflight  output  CNT_W  CREDITS − credits
- state_idle  output  1  FSM is in IDLE
- cr_err  output  1  sticky; credit overflow detected

## Operation
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE → ACTIVE when link_en=1.
  - ACTIVE → DRAIN when link_en=0.
  - DRAIN → IDLE when credits==CREDITS and tx_valid==0.
  - DRAIN → ACTIVE when link_en=1 (takes precedence over the IDLE exit).
- s_ready = (state==ACTIVE) && (credits!=0). Combinational from registered state only; no dependence on s_valid.
- send = s_valid && s_ready. Each send consumes one credit.
- Credit return adds cr_ret_cnt when cr_ret_valid=1. It is accepted in every state, including IDLE and DRAIN.
- credits_next = credits − send + (cr_ret_valid ? cr_ret_cnt : 0), computed at CNT_W+1 bits.
- If credits_next > CREDITS: credits saturates at CREDITS and cr_err sets. cr_err clears only on rst.
- Simultaneous send and return in the same cycle: net update. A return with credits==0 does not enable a send in that same cycle.
- No data buffering beyond the single output register. Words are delivered in order, with no loss or duplication.

## Timing
- Reset values: state=IDLE, credits=CREDITS, inflight=0, tx_valid=0, tx_data=0, cr_err=0, state_idle=1, s_ready=0.
- rst asserted mid-operation: everything returns to the reset values on the next edge. In-flight words are abandoned and credits restore to CREDITS.
- Latency: a word accepted at edge N appears with tx_valid=1 and tx_data=s_data in the cycle after edge N. Exactly 1 cycle.
- tx_valid is a registered copy of send. Back-to-back sends produce contiguous tx_valid cycles.
- A credit returned at edge N is visible in credits, and therefore in s_ready, from edge N onward (1-cycle turnaround).
- link_en sampled 1 at edge N → s_ready may rise in the cycle after edge N (ACTIVE).
- link_en=0 at edge N → s_ready=0 from that edge onward. A word sent at edge N still emits its tx_valid.
- state_idle rises on the edge after the last outstanding credit returns, provided tx_valid is low in that cycle.

## Test plan
- Reset and enable: rst 2 cycles, then link_en=1 with s_valid=1 continuously and no returns.
  - Expect exactly 8 words tx_valid in 8 consecutive cycles (data 0..7 in order).
  - Then credits=0, s_ready=0, inflight=8.
- Steady flow: CREDITS=8, receiver model returns 1 credit 3 cycles after each tx_valid.
  - Expect sustained throughput with no stall once in steady state.
  - Expect credits to never exceed 8 or underflow.
  - 100 words arrive in order.
- Simultaneous events: with credits=1, assert send and cr_ret_valid with cr_ret_cnt=2 in the same cycle.
  - Expect credits=2 on the next cycle.
  - Separately, with credits=0, assert a return with cr_ret_cnt=1: expect s_ready=0 that cycle and 1 the next.
- Drain: after 5 sends with no returns, drop link_en.
  - Expect s_ready=0 immediately, state=DRAIN, state_idle=0.
  - Return 2, then 3 credits: expect state_idle=1 one edge after the second return.
  - Raise link_en mid-drain: expect return to ACTIVE.
- Overflow: at credits=8, strobe cr_ret_cnt=1.
  - Expect credits stays 8 and cr_err=1, which persists until rst.
- Mid-operation reset: assert rst while credits=3 and tx_valid=1.
  - Expect all outputs at their reset values after that edge, with credits=8.

Source files
------------

// File: rtl/credit_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : credit_tx_if
//  Description : Source handshake, link output and credit-return bundle for
//                the credit-based link transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface credit_tx_if #(
    parameter int DATA_W  = 32,
    parameter int CREDITS = 8
);
    localparam int CNT_W = $clog2(CREDITS + 1);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              cr_ret_valid;
    logic [CNT_W-1:0]  cr_ret_cnt;

    // Transmitter side
    modport master (
        input  s_valid, s_data, cr_ret_valid, cr_ret_cnt,
        output s_ready, tx_valid, tx_data
    );

    // Source / receiver side
    modport slave (
        output s_valid, s_data, cr_ret_valid, cr_ret_cnt,
        input  s_ready, tx_valid, tx_data
    );
endinterface
`default_nettype wire

// File: rtl/credit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : credit_tx
//  Description : Credit-based link transmitter. Forwards ready/valid source
//                words onto a link without backpressure, one word per held
//                credit, and reclaims credits returned by the receiver.
//                An IDLE/ACTIVE/DRAIN machine quiesces the link with all
//                credits home.
//  Revision    : 1.0 - initial release
// ============================================================================
module credit_tx #(
    parameter int DATA_W  = 32,
    parameter int CREDITS = 8,
    localparam int CNT_W  = $clog2(CREDITS + 1)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       link_en,
    credit_tx_if.master     bus,
    output logic [CNT_W-1:0] credits,
    output logic [CNT_W-1:0] inflight,
    output logic            state_idle,
    output logic            cr_err
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_DRAIN  = 2'd2;

    localparam logic [CNT_W-1:0] c_CREDITS   = CNT_W'(CREDITS);
    localparam logic [CNT_W:0]   c_CREDITS_X = (CNT_W + 1)'(CREDITS);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [CNT_W-1:0]  r_credits;
    logic              r_cr_err;
    logic              r_tx_valid;
    logic [DATA_W-1:0] r_tx_data;
    logic              w_s_ready;
    logic              w_send;
    logic [CNT_W:0]    w_ret;
    logic [CNT_W:0]    w_sum;

    // Source is offered a slot only from registered state, never from s_valid
    assign w_s_ready = (r_state == c_ST_ACTIVE) && (r_credits != '0);
    assign w_send    = bus.s_valid && w_s_ready;

    // One extra bit so an over-return is detectable rather than wrapping
    assign w_ret = bus.cr_ret_valid ? {1'b0, bus.cr_ret_cnt} : '0;
    assign w_sum = {1'b0, r_credits} - {{CNT_W{1'b0}}, w_send} + w_ret;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: re-enable during drain wins over reaching idle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (link_en) w_state_next = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (!link_en) w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (link_en) begin
                    w_state_next = c_ST_ACTIVE;
                end else if ((r_credits == c_CREDITS) && !r_tx_valid) begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Credit counter: net of send and return, saturating with sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= c_CREDITS;
            r_cr_err  <= 1'b0;
        end else if (w_sum > c_CREDITS_X) begin
            r_credits <= c_CREDITS;
            r_cr_err  <= 1'b1;
        end else begin
            r_credits <= w_sum[CNT_W-1:0];
        end
    end

    // Single output register; data holds between words
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_tx_valid <= w_send;
            if (w_send) r_tx_data <= bus.s_data;
        end
    end

    assign bus.s_ready  = w_s_ready;
    assign bus.tx_valid = r_tx_valid;
    assign bus.tx_data  = r_tx_data;
    assign credits      = r_credits;
    assign inflight     = c_CREDITS - r_credits;
    assign state_idle   = (r_state == c_ST_IDLE);
    assign cr_err       = r_cr_err;

endmodule
`default_nettype wire

// File: tb/tb_credit_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_credit_tx
//  Description : Directed self-checking bench for credit_tx.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_credit_tx;

    localparam int c_DATA_W  = 32;
    localparam int c_CREDITS = 8;
    localparam int c_CNT_W   = $clog2(c_CREDITS + 1);

    logic               clk;
    logic               rst;
    logic               link_en;
    logic [c_CNT_W-1:0] credits;
    logic [c_CNT_W-1:0] inflight;
    logic               state_idle;
    logic               cr_err;

    int n_tests;
    int n_fail;

    credit_tx_if #(.DATA_W(c_DATA_W), .CREDITS(c_CREDITS)) bus ();

    credit_tx #(.DATA_W(c_DATA_W), .CREDITS(c_CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .link_en    (link_en),
        .bus        (bus),
        .credits    (credits),
        .inflight   (inflight),
        .state_idle (state_idle),
        .cr_err     (cr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then observed 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        link_en          = 1'b0;
        bus.s_valid      = 1'b0;
        bus.s_data       = '0;
        bus.cr_ret_valid = 1'b0;
        bus.cr_ret_cnt   = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (credits !== 4'd8) begin n_fail++; $display("FAIL reset_credits got %0d exp 8", credits); end
        n_tests++; if (inflight !== 4'd0) begin n_fail++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
        n_tests++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %0b exp 0", bus.tx_valid); end
        n_tests++; if (bus.tx_data !== 32'd0) begin n_fail++; $display("FAIL reset_tx_data got %0h exp 0", bus.tx_data); end
        n_tests++; if (cr_err !== 1'b0) begin n_fail++; $display("FAIL reset_cr_err got %0b exp 0", cr_err); end
        n_tests++; if (state_idle !== 1'b1) begin n_fail++; $display("FAIL reset_state_idle got %0b exp 1", state_idle); end
        n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready got %0b exp 0", bus.s_ready); end
    endtask

    task automatic test_fill();
        do_reset();
        link_en     = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 32'd0;
        tick();
        n_tests++; if (bus.s_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_en got %0b exp 1", bus.s_ready); end
        n_tests++; if (state_idle !== 1'b0) begin n_fail++; $display("FAIL fill_not_idle got %0b exp 0", state_idle); end
        for (int i = 0; i < 8; i++) begin
            bus.s_data = 32'(i);
            tick();
            n_tests++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'(i) || credits !== 4'(7 - i)) begin
                n_fail++;
                $display("FAIL fill_word%0d got v=%0b d=%0d cr=%0d exp v=1 d=%0d cr=%0d",
                         i, bus.tx_valid, bus.tx_data, credits, i, 7 - i);
            end
        end
        bus.s_data = 32'd8;
        tick();
        n_tests++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL fill_no_ninth got %0b exp 0", bus.tx_valid); end
        n_tests++; if (credits !== 4'd0) begin n_fail++; $display("FAIL fill_credits got %0d exp 0", credits); end
        n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL fill_s_ready got %0b exp 0", bus.s_ready); end
        n_tests++; if (inflight !== 4'd8) begin n_fail++; $display("FAIL fill_inflight got %0d exp 8", inflight); end
    endtask

    task automatic test_steady();
        int       src;
        int       exp_idx;
        int       first;
        int       last;
        logic [3:0] pipe;
        do_reset();
        link_en = 1'b1;
        tick();
        src = 0; exp_idx = 0; first = -1; last = -1; pipe = '0;
        for (int cyc = 0; cyc < 400 && exp_idx < 100; cyc++) begin
            bus.s_valid      = (src < 100);
            bus.s_data       = 32'(src + 1000);
            bus.cr_ret_valid = pipe[3];
            bus.cr_ret_cnt   = 4'd1;
            tick();
            if (bus.tx_valid === 1'b1) begin
                n_tests++;
                if (bus.tx_data !== 32'(exp_idx + 1000)) begin
                    n_fail++;
                    $display("FAIL steady_data got %0d exp %0d", bus.tx_data, exp_idx + 1000);
                end
                if (first < 0) first = cyc;
                last = cyc;
                exp_idx++;
                src++;
            end
            n_tests++;
            if (credits > 4'd8) begin
                n_fail++;
                $display("FAIL steady_credit_range got %0d exp <=8", credits);
            end
            pipe = {pipe[2:0], bus.tx_valid};
        end
        n_tests++; if (exp_idx !== 100) begin n_fail++; $display("FAIL steady_count got %0d exp 100", exp_idx); end
        n_tests++; if (last - first + 1 !== 100) begin n_fail++; $display("FAIL steady_no_stall got span %0d exp 100", last - first + 1); end
        bus.s_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.cr_ret_valid = pipe[3];
            tick();
            pipe = {pipe[2:0], bus.tx_valid};
        end
        bus.cr_ret_valid = 1'b0;
        n_tests++; if (credits !== 4'd8) begin n_fail++; $display("FAIL steady_credits_home got %0d exp 8", credits); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        link_en = 1'b1;
        tick();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.s_data = 32'(i);
            tick();
        end
        n_tests++; if (credits !== 4'd1) begin n_fail++; $display("FAIL simul_pre_credits got %0d exp 1", credits); end
        bus.s_data       = 32'hABCD;
        bus.cr_ret_valid = 1'b1;
        bus.cr_ret_cnt   = 4'd2;
        tick();
        bus.cr_ret_valid = 1'b0;
        n_tests++; if (credits !== 4'd2) begin n_fail++; $display("FAIL simul_net_credits got %0d exp 2", credits); end
        n_tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'hABCD) begin n_fail++; $display("FAIL simul_send got v=%0b d=%0h exp v=1 d=abcd", bus.tx_valid, bus.tx_data); end
        tick();
        tick();
        n_tests++; if (credits !== 4'd0) begin n_fail++; $display("FAIL simul_empty got %0d exp 0", credits); end
        bus.cr_ret_valid = 1'b1;
        bus.cr_ret_cnt   = 4'd1;
        #1;
        n_tests++; if (bus.s_ready !== 1'b0) begin n_fail++; $display("FAIL simul_ret_no_bypass got %0b exp 0", bus.s_ready); end
        tick();
        bus.cr_ret_valid = 1'b0;
        bus.s_valid      = 1'b0;
        n_tests++; if (bus.tx_valid !== 1'b0) begin n_fail++; $display("FAIL simul_no_send got %0b exp 0", bus.tx_valid); end
        n_tests++; if (bus.s_ready !== 1'b1 || credits !== 4'd1) begin n_fail++; $display("FAIL simul_ready_next got r=%0b cr=%0d exp r=1 cr=1", bus.s_ready, credits); end
    endtask

    task automatic test_drain();
        do_reset();
        link_en = 1'b1;
        tick();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data = 32'(i + 50);
            if (i == 4) link_en = 1'b0;
            tick();
        end
        bus.s_valid = 1'b0;
        n_tests++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 32'd54) begin n_fail++; $display("FAIL drain_last_word got v=%0b d=%0d exp v=1 d=54", bus.tx_valid, bus.tx_data); end
        n_tests++; if (bus.s_ready !== 1'b0 || state_idle !== 1'b0) begin n_fail++; $display("FAIL drain_entry got r=%0b idle=%0b exp r=0 idle=0", bus.s_ready, state_idle); end
        n_tests++; if (credits !== 4'd3 || inflight !== 4'd5) begin n_fail++; $display("FAIL drain_counts got cr=%0d inf=%0d exp cr=3 inf=5", credits, inflight); end
        bus.cr_ret_valid = 1'b1;
        bus.cr_ret_cnt   = 4'd2;
        tick();
        n_tests++; if (credits !== 4'd5 || state_idle !== 1'b0) begin n_fail++; $display("FAIL drain_ret2 got cr=%0d idle=%0b exp cr=5 idle=0", credits, state_idle); end
        bus.cr_ret_cnt = 4'd3;
        tick();
        bus.cr_ret_valid = 1'b0;
        n_tests++; if (credits !== 4'd8 || state_idle !== 1'b0) begin n_fail++; $display("FAIL drain_ret3 got cr=%0d idle=%0b exp cr=8 idle=0", credits, state_idle); end
        tick();
        n_tests++; if (state_idle !== 1'b1) begin n_fail++; $display("FAIL drain_idle got %0b exp 1", state_idle); end
        // Second drain, aborted by re-enable before credits come home
        link_en = 1'b1;
        tick();
        bus.s_valid = 1'b1;
        tick();
        tick();
        bus.s_valid = 1'b0;
        link_en     = 1'b0;
        tick();
        n_tests++; if (bus.s_ready !== 1'b0 || credits !== 4'd6) begin n_fail++; $display("FAIL redrain_entry got r=%0b cr=%0d exp r=0 cr=6", bus.s_ready, credits); end
        link_en = 1'b1;
        tick();
        n_tests++; if (bus.s_ready !== 1'b1 || state_idle !== 1'b0) begin n_fail++; $display("FAIL redrain_reactivate got r=%0b idle=%0b exp r=1 idle=0", bus.s_ready, state_idle); end
    endtask

    task automatic test_overflow();
        do_reset();
        bus.cr_ret_valid = 1'b1;
        bus.cr_ret_cnt   = 4'd1;
        tick();
        bus.cr_ret_valid = 1'b0;
        n_tests++; if (credits !== 4'd8 || cr_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set got cr=%0d err=%0b exp cr=8 err=1", credits, cr_err); end
        tick();
        tick();
        tick();
        n_tests++; if (cr_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %0b exp 1", cr_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++; if (cr_err !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0b exp 0", cr_err); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        link_en = 1'b1;
        tick();
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data = 32'(i + 7);
            tick();
        end
        n_tests++; if (credits !== 4'd3 || bus.tx_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre got cr=%0d v=%0b exp cr=3 v=1", credits, bus.tx_valid); end
        rst = 1'b1;
        tick();
        n_tests++;
        if (credits !== 4'd8 || inflight !== 4'd0 || bus.tx_valid !== 1'b0 || bus.tx_data !== 32'd0 ||
            cr_err !== 1'b0 || state_idle !== 1'b1 || bus.s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_values got cr=%0d inf=%0d v=%0b d=%0h err=%0b idle=%0b r=%0b exp cr=8 inf=0 v=0 d=0 err=0 idle=1 r=0",
                     credits, inflight, bus.tx_valid, bus.tx_data, cr_err, state_idle, bus.s_ready);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        clear_inputs();
        test_reset();
        test_fill();
        test_steady();
        test_simultaneous();
        test_drain();
        test_overflow();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
